// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared state encoding, operation codes and default width
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int NIBBLES_DEFAULT = 8;

endpackage

// File: rtl/RippleCarryAdder.sv
// rtl/RippleCarryAdder.sv - 4-bit ripple-carry adder shared by the serial datapath
//
// Ports:
//   A, B  : 4-bit addends
//   Cin   : carry in
//   Sum   : 4-bit sum
//   Cout  : carry out of bit 3
module RippleCarryAdder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic c;

    always_comb begin
        c   = Cin;
        Sum = '0;
        for (int i = 0; i < 4; i++) begin
            Sum[i] = A[i] ^ B[i] ^ c;
            c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
        end
        Cout = c;
    end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - nibble-serial W-bit add/subtract unit with IDLE/RUN/DONE control
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, op, a, b : operation request; sampled only while ready
//   ready, busy     : IDLE / RUN state indicators
//   done            : one-cycle pulse in DONE
//   result          : W-bit sum or difference, held until the next accepted start
//   carry, ovf, zero: carry out (1 = no borrow on subtract), signed overflow, result == 0
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 carry,
    output logic                 ovf,
    output logic                 zero
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

    state_t         state, next_state;
    logic [W-1:0]   a_reg, b_reg, res_reg;
    logic [CW-1:0]  cnt;
    logic           carry_reg, ovf_reg, op_reg;
    logic           a_msb, b_msb;
    logic [3:0]     sum;
    logic           cout;
    logic           accept, last;

    assign accept = (state == IDLE) && start;
    assign last   = (cnt == CNT_LAST);

    RippleCarryAdder u_adder (
        .A   (a_reg[3:0]),
        .B   (b_reg[3:0]),
        .Cin (carry_reg),
        .Sum (sum),
        .Cout(cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted on capture and the carry
    // register is seeded with op so the first nibble supplies the +1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            cnt       <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            op_reg    <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= (op == OP_SUB) ? ~b : b;
            cnt       <= '0;
            carry_reg <= op;
            op_reg    <= op;
            a_msb     <= a[W-1];
            b_msb     <= b[W-1];
        end else if (state == RUN) begin
            a_reg     <= a_reg >> 4;
            b_reg     <= b_reg >> 4;
            res_reg   <= {sum, res_reg[W-1:4]};
            carry_reg <= cout;
            if (last) begin
                // sum[3] is the sign bit of the finished result; b_msb is the
                // original (uninverted) operand sign.
                if (op_reg == OP_SUB) begin
                    ovf_reg <= (a_msb != b_msb) && (sum[3] != a_msb);
                end else begin
                    ovf_reg <= (a_msb == b_msb) && (sum[3] != a_msb);
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign result = res_reg;
    assign carry  = carry_reg;
    assign ovf    = ovf_reg;
    assign zero   = (res_reg == '0);

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - directed vector bench for serial_addsub_ctrl (NIBBLES=8)
module tb_serial_addsub_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] a, b;
    logic        ready, busy, done;
    logic [31:0] result;
    logic        carry, ovf, zero;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        carry;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    serial_addsub_ctrl #(.NIBBLES(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .result(result),
        .carry (carry),
        .ovf   (ovf),
        .zero  (zero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ready"},  32'(ready),  32'd1);
        chk({tag, " busy"},   32'(busy),   32'd0);
        chk({tag, " done"},   32'(done),   32'd0);
        chk({tag, " result"}, result,      32'd0);
        chk({tag, " carry"},  32'(carry),  32'd0);
        chk({tag, " ovf"},    32'(ovf),    32'd0);
        chk({tag, " zero"},   32'(zero),   32'd1);
    endtask

    // Latency counts the accepting edge as edge 1; done must appear on edge 9.
    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        chk({v.name, " ready before"}, 32'(ready), 32'd1);
        op = v.op; a = v.a; b = v.b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = $urandom_range(0, 1);
        chk({v.name, " busy after accept"}, 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({v.name, " latency"}, 32'(lat),   32'd9);
        chk({v.name, " result"},  result,     v.res);
        chk({v.name, " carry"},   32'(carry), 32'(v.carry));
        chk({v.name, " ovf"},     32'(ovf),   32'(v.ovf));
        chk({v.name, " zero"},    32'(zero),  32'(v.zero));
        @(negedge clk);
        chk({v.name, " done width"}, 32'(done),  32'd0);
        chk({v.name, " ready back"}, 32'(ready), 32'd1);
        repeat (2) @(negedge clk);
        chk({v.name, " result held"}, result, v.res);
    endtask

    initial begin
        vec_t v;
        int   dones, rises, prev_rise, prev_busy, prev_done;

        vecs[0] = '{"sub 5-3",       1'b1, 32'h00000005, 32'h00000003, 32'h00000002, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{"sub 0-1",       1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{"add maxpos+1",  1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"add -1+1",      1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{"sub minneg-1",  1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{"add mixed",     1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{"sub equal",     1'b1, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{"add minneg x2", 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{"sub 10-1",      1'b1, 32'h00000010, 32'h00000001, 32'h0000000F, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // start pulsed mid-RUN with new operands must be ignored
        @(negedge clk);
        op = 1'b0; a = 32'h12345678; b = 32'h11111111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        op = 1'b1; a = 32'hAAAAAAAA; b = 32'h00000001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0; rises = 0; prev_busy = 1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        chk("ignored start done count", 32'(dones), 32'd1);
        chk("ignored start accepts",    32'(rises), 32'd0);
        chk("ignored start result",     result,     32'h23456789);

        // reset during the fourth RUN cycle, then a normal operation
        @(negedge clk);
        op = 1'b0; a = 32'h12345678; b = 32'h11111111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy before mid-run reset", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1 chk_reset_outputs("mid-run reset");
        @(negedge clk);
        rst = 1'b0;
        v = '{"post-reset sub 10-1", 1'b1, 32'h00000010, 32'h00000001, 32'h0000000F, 1'b1, 1'b0, 1'b0};
        run_vec(v);

        // start held high: accept every NIBBLES+2 edges, single-cycle done
        @(negedge clk);
        op = 1'b0; a = 32'h00000001; b = 32'h00000002; start = 1'b1;
        dones = 0; rises = 0; prev_busy = 0; prev_done = 0; prev_rise = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                if (prev_rise >= 0) chk("back-to-back period", 32'(i - prev_rise), 32'd10);
                prev_rise = i;
                rises++;
            end
            if (done) begin
                dones++;
                chk("back-to-back done single", 32'(prev_done), 32'd0);
                chk("back-to-back result", result, 32'h00000003);
            end
            prev_busy = busy;
            prev_done = done;
        end
        start = 1'b0;
        chk("back-to-back accepts", 32'(rises), 32'd4);
        chk("back-to-back dones",   32'(dones), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 Parameter NIBBLES, default 8, sets operand width W = 4*NIBBLES bits, legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only when ready=1.
REQ-005 op  input  1  0 = add A+B, 1 = subtract A-B; sampled with start.
REQ-006 a  input  W  operand A; sampled with start.
REQ-007 b  input  W  operand B; sampled with start.
REQ-008 ready  output  1  high only in IDLE.
REQ-009 busy  output  1  high only in RUN.
REQ-010 done  output  1  single-cycle pulse, high only in DONE.
REQ-011 result  output  W  sum or difference; held stable from DONE until the next accepted start.
REQ-012 carry  output  1  final carry out of the MSB nibble (for subtract: 1 = no borrow).
REQ-013 ovf  output  1  signed two's-complement overflow of the W-bit operation.
REQ-014 zero  output  1  high when result == 0.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 Transitions: IDLE->RUN on start=1; RUN->DONE after NIBBLES RUN cycles; DONE->IDLE unconditionally after one cycle.
REQ-017 The accepting edge SHALL latch a, op and (op ? ~b : b) into internal shift registers, clear the nibble counter, and load the carry register with op.
REQ-018 Each RUN cycle SHALL feed one nibble into a single shared 4-bit adder, LSB nibble first, with Cin = carry register: A = a_reg[3:0], B = b_reg[3:0].
REQ-019 On each RUN edge, the adder sum SHALL shift into result from the MSB end, a_reg and b_reg SHALL shift right by 4, carry SHALL take adder Cout, and the counter SHALL increment.
REQ-020 The counter SHALL be ceil(log2(NIBBLES)) bits wide; RUN->DONE fires on the edge where counter == NIBBLES-1, with no wrap-around beyond that value.
REQ-021 Latency: done SHALL be high exactly NIBBLES+1 rising edges after the accepting edge, and ready SHALL return high one edge later.
REQ-022 ovf SHALL be computed at the final RUN edge from the latched operand sign bits and the result sign bit.
REQ-022a Add: ovf = (a_msb == b_msb) && (res_msb != a_msb).
REQ-022b Subtract: ovf = (a_msb != b_msb) && (res_msb != a_msb).
REQ-023 start asserted during RUN or DONE SHALL be ignored, with no queuing; operand inputs are don't-care outside the accepting edge.
REQ-024 zero SHALL be derived combinationally from the result register.

Reset
REQ-025 Asserting rst at any time, including mid-RUN, SHALL immediately force the following: state=IDLE, ready=1, busy=0, done=0, result=0, carry=0, ovf=0, zero=1, counter=0.
REQ-026 Reset SHALL discard any partial operation; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-027 Shared package addsub_pkg SHALL hold the state enum (IDLE, RUN, DONE), the OP_ADD/OP_SUB encodings and the NIBBLES default.
REQ-028 The 4-bit datapath SHALL be one instance of the existing RippleCarryAdder sub-module (A, B, Cin, Sum, Cout); no other arithmetic on operand data.

Verification (NIBBLES=8)
REQ-029 Sub: a=0x00000005, b=0x00000003 -> result=0x00000002, carry=1, ovf=0, zero=0; done 9 edges after accept.
REQ-030 Sub: a=0x00000000, b=0x00000001 -> result=0xFFFFFFFF, carry=0, ovf=0.
REQ-031 Add: a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, ovf=1, carry=0. Add: a=0xFFFFFFFF, b=0x00000001 -> result=0, carry=1, zero=1.
REQ-032 start pulsed with new operands during RUN -> ignored; first operation's result is unchanged, and exactly one done pulse occurs.
REQ-033 rst asserted at RUN cycle 4 -> all outputs take reset values immediately; a following start with a=0x10, b=0x01, op=sub -> result=0x0000000F.
REQ-034 Back-to-back: start held high continuously -> accepts occur every NIBBLES+2 edges, each with a single-cycle done.
